// File: rtl/empty_slot_reader.sv
// Drain-side sequencer for the MxV result bank: scans slots in index order,
// streams every non-empty (not all-ones) slot over valid/ready, then clears it.
module empty_slot_reader #(
  parameter int Word_Length = 34,
  parameter int Depth       = 8,
  localparam int IdxW       = $clog2(Depth),
  localparam int CntW       = $clog2(Depth + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sys_reset,
  input  logic                         start,
  input  logic [Depth*Word_Length-1:0] slot_data,
  input  logic                         out_ready,
  output logic [Word_Length-1:0]       out_data,
  output logic                         out_valid,
  output logic [IdxW-1:0]              out_index,
  output logic [Depth-1:0]             slot_clear,
  output logic [CntW-1:0]              sent_count,
  output logic                         busy,
  output logic                         done
);

  // state | meaning
  // IDLE  | waiting for start
  // SCAN  | evaluating slot idx
  // SEND  | presenting captured slot until out_ready
  // DONE  | one-cycle end-of-scan pulse
  typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

  localparam logic [IdxW-1:0]        LastIdx = IdxW'(Depth - 1);
  localparam logic [Word_Length-1:0] Empty   = {Word_Length{1'b1}};

  state_t                 state, state_nxt;
  logic [IdxW-1:0]        idx, idx_nxt;
  logic                   capture, xfer;
  logic [Word_Length-1:0] slot [Depth];
  logic [Word_Length-1:0] cur_slot;

  for (genvar g = 0; g < Depth; g++) begin : g_unpack
    assign slot[g] = slot_data[g*Word_Length +: Word_Length];
  end

  assign cur_slot  = slot[idx];
  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else if (sys_reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    xfer      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (cur_slot == Empty) begin
          if (idx == LastIdx) state_nxt = DONE;
          else                idx_nxt   = idx + IdxW'(1);
        end else begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          xfer = 1'b1;
          if (idx == LastIdx) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            idx_nxt   = idx + IdxW'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear pulse is registered so it lands in the cycle after the transfer edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= Empty;
      out_index  <= '0;
      slot_clear <= '0;
      sent_count <= '0;
    end else if (sys_reset) begin
      out_data   <= Empty;
      out_index  <= '0;
      slot_clear <= '0;
      sent_count <= '0;
    end else begin
      slot_clear <= '0;
      if (capture) begin
        out_data  <= cur_slot;
        out_index <= idx;
      end
      if (state == IDLE && start) begin
        sent_count <= '0;
      end else if (xfer) begin
        sent_count <= sent_count + CntW'(1);
        slot_clear <= Depth'(1) << out_index;
      end
    end
  end

endmodule

// File: tb/tb_empty_slot_reader.sv
// Bench for empty_slot_reader: directed test-plan scenarios plus a randomized run,
// all checked every cycle against a queue-based timeline model of the scan.
module tb_empty_slot_reader;
  localparam int W = 34;
  localparam int D = 8;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam int K_SCAN = 0, K_SEND = 1, K_DONE = 2;

  typedef struct {
    int           kind;
    int           idx;
    logic [W-1:0] data;
  } ev_t;

  logic           clk = 1'b0;
  logic           reset, sys_reset, start, out_ready;
  logic [D*W-1:0] slot_data;
  logic [W-1:0]   out_data;
  logic           out_valid, busy, done;
  logic [2:0]     out_index;
  logic [D-1:0]   slot_clear;
  logic [3:0]     sent_count;

  logic [W-1:0]   bank [D];

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // timeline model: one entry per expected cycle, SEND entries persist while stalled
  ev_t          q [$];
  logic [D-1:0] exp_clear = '0;
  int           exp_count = 0;

  int busy_cyc, valid_cyc, done_cnt;
  ev_t          xfer_log [$];
  logic [D-1:0] clr_log [$];

  empty_slot_reader #(.Word_Length(W), .Depth(D)) dut (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .start(start),
    .slot_data(slot_data), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .out_index(out_index), .slot_clear(slot_clear),
    .sent_count(sent_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    slot_data = '0;
    for (int i = 0; i < D; i++) slot_data[i*W +: W] = bank[i];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int front_kind();
    if (q.size() == 0) return -1;
    return q[0].kind;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || sys_reset) begin
      q.delete();
      exp_clear = '0;
      exp_count = 0;
    end else begin
      exp_clear = '0;
      if (q.size() == 0) begin
        if (start) begin
          exp_count = 0;
          for (int i = 0; i < D; i++) begin
            q.push_back('{K_SCAN, i, ONES});
            if (bank[i] != ONES) q.push_back('{K_SEND, i, bank[i]});
          end
          q.push_back('{K_DONE, 0, ONES});
        end
      end else if (q[0].kind == K_SEND) begin
        if (out_ready) begin
          exp_count++;
          exp_clear[q[0].idx] = 1'b1;
          void'(q.pop_front());
        end
      end else begin
        void'(q.pop_front());
      end
    end
  end

  always @(posedge clk)
    if (!reset && !sys_reset && out_valid && out_ready)
      xfer_log.push_back('{K_SEND, int'(out_index), out_data});

  always @(negedge clk) begin
    busy_cyc  += int'(busy);
    valid_cyc += int'(out_valid);
    done_cnt  += int'(done);
    if (slot_clear != '0) clr_log.push_back(slot_clear);
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("done", 64'(done), 64'(front_kind() == K_DONE));
      chk("out_valid", 64'(out_valid), 64'(front_kind() == K_SEND));
      if (front_kind() == K_SEND) begin
        chk("out_data", 64'(out_data), 64'(q[0].data));
        chk("out_index", 64'(out_index), 64'(q[0].idx));
      end
      chk("slot_clear", 64'(slot_clear), 64'(exp_clear));
      chk("sent_count", 64'(sent_count), 64'(exp_count));
    end
  end

  task automatic clear_mon();
    busy_cyc = 0; valid_cyc = 0; done_cnt = 0;
    xfer_log.delete(); clr_log.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("scan_terminates", 64'(busy), 64'(0));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("valid_reached", 64'(out_valid), 64'(1));
  endtask

  task automatic fill_empty();
    for (int i = 0; i < D; i++) bank[i] = ONES;
  endtask

  initial begin
    reset = 1'b1; sys_reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    fill_empty();
    repeat (2) @(negedge clk);
    chk("rst_out_data", 64'(out_data), 64'(34'h3_FFFF_FFFF));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sent_count", 64'(sent_count), 64'(0));
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // all-empty bank
    clear_mon();
    pulse_start();
    wait_idle();
    chk("empty_busy_cycles", 64'(busy_cyc), 64'(9));
    chk("empty_valid_cycles", 64'(valid_cyc), 64'(0));
    chk("empty_done_pulses", 64'(done_cnt), 64'(1));
    chk("empty_sent_count", 64'(sent_count), 64'(0));

    // slots 1, 4, 7 populated, ready tied high
    bank[1] = 34'h5; bank[4] = 34'h1_0000_0000; bank[7] = 34'h0;
    out_ready = 1'b1;
    clear_mon();
    pulse_start();
    wait_idle();
    chk("three_busy_cycles", 64'(busy_cyc), 64'(12));
    chk("three_sent_count", 64'(sent_count), 64'(3));
    chk("three_xfers", 64'(xfer_log.size()), 64'(3));
    chk("three_clears", 64'(clr_log.size()), 64'(3));
    if (xfer_log.size() == 3 && clr_log.size() == 3) begin
      chk("xfer0_idx", 64'(xfer_log[0].idx), 64'(1));
      chk("xfer0_data", 64'(xfer_log[0].data), 64'(34'h5));
      chk("xfer1_idx", 64'(xfer_log[1].idx), 64'(4));
      chk("xfer1_data", 64'(xfer_log[1].data), 64'(34'h1_0000_0000));
      chk("xfer2_idx", 64'(xfer_log[2].idx), 64'(7));
      chk("xfer2_data", 64'(xfer_log[2].data), 64'(34'h0));
      chk("clear0", 64'(clr_log[0]), 64'(8'h02));
      chk("clear1", 64'(clr_log[1]), 64'(8'h10));
      chk("clear2", 64'(clr_log[2]), 64'(8'h80));
    end

    // start held high during the scan is ignored
    clear_mon();
    @(negedge clk) start = 1'b1;
    while (!done && busy_cyc < 100) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("restart_done_pulses", 64'(done_cnt), 64'(1));
    chk("restart_busy_cycles", 64'(busy_cyc), 64'(12));

    // slot 0 stalled for 5 cycles
    fill_empty();
    bank[0] = 34'hABC;
    out_ready = 1'b0;
    clear_mon();
    pulse_start();
    wait_valid();
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    wait_idle();
    chk("stall_valid_cycles", 64'(valid_cyc), 64'(6));
    chk("stall_clears", 64'(clr_log.size()), 64'(1));
    if (clr_log.size() == 1) chk("stall_clear0", 64'(clr_log[0]), 64'(8'h01));

    // async reset between edges while in SEND
    clear_mon();
    pulse_start();
    wait_valid();
    #1 reset = 1'b1;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'(0));
    chk("areset_out_data", 64'(out_data), 64'(34'h3_FFFF_FFFF));
    chk("areset_busy", 64'(busy), 64'(0));
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("areset_no_clear", 64'(clr_log.size()), 64'(0));

    // sys_reset on the same edge as a would-be transfer
    clear_mon();
    pulse_start();
    wait_valid();
    out_ready = 1'b1; sys_reset = 1'b1;
    @(negedge clk);
    sys_reset = 1'b0; out_ready = 1'b0;
    chk("sreset_busy", 64'(busy), 64'(0));
    chk("sreset_sent_count", 64'(sent_count), 64'(0));
    repeat (3) @(negedge clk);
    chk("sreset_no_clear", 64'(clr_log.size()), 64'(0));
    chk("sreset_no_done", 64'(done_cnt), 64'(0));

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (q.size() == 0 && ($urandom % 3) == 0) begin
        for (int i = 0; i < D; i++) begin
          case ($urandom % 4)
            0, 1: bank[i] = ONES;
            2:    bank[i] = {$urandom, $urandom} & 64'(ONES);
            default: bank[i] = W'($urandom % 3);
          endcase
        end
      end
      start     = (($urandom % 3) == 0);
      out_ready = (($urandom % 10) < 7);
      sys_reset = (($urandom % 300) == 0);
    end
    @(negedge clk);
    start = 1'b0; sys_reset = 1'b0; out_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
